fused_pe: RTL
=============

FUSED_PE -- requirements
Module: fused_pe

Interface
REQ-001 Parameter NUM_BB, default 4: 2-bit brick multipliers evaluated per cycle; legal values 1, 2, 4, 8, 16.
REQ-002 Parameter ACC_W, default 32: accumulator width; legal range 18..64.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand request valid.
REQ-006 in_ready  output  1  block can accept operands.
REQ-007 x, y  input  8 each  operands, LSB-aligned to selected precision.
REQ-008 s_x, s_y  input  1 each  1 = operand signed (two's complement), 0 = unsigned.
REQ-009 x_prec, y_prec  input  2 each  0 = 2-bit, 1 = 4-bit, 2 or 3 = 8-bit.
REQ-010 acc_clr  input  1  1 = discard old accumulator and start from 0.
REQ-011 out_valid  output  1  acc holds a completed result.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 acc  output  ACC_W  accumulator value.
REQ-014 busy  output  1  high in COMPUTE or DONE.

Function
REQ-015 Operand x SHALL be x[P-1:0], where P is the precision selected by x_prec; it SHALL be sign-extended when s_x=1 and zero-extended otherwise. Upper bits are ignored. The same rule applies to y.
REQ-016 Each operand SHALL be split into C = P/2 two-bit chunks (Cx, Cy). Chunk i SHALL be signed only when its sign flag = 1 and i = C-1; all other chunks are unsigned.
REQ-017 Brick k = i*Cy + j (k = 0 .. Cx*Cy-1) SHALL produce x-chunk i times y-chunk j, shifted left by 2*(i+j) and sign-extended.
REQ-018 A brick index >= Cx*Cy SHALL contribute 0.
REQ-019 State machine states: IDLE, COMPUTE, DONE.
REQ-020 IDLE: in_ready = 1; on in_valid & in_ready the block SHALL register x, y, s_x, s_y, x_prec, y_prec and acc_clr, clear the internal partial sum and brick-group counter, and go to COMPUTE.
REQ-021 COMPUTE: each cycle SHALL add bricks g*NUM_BB .. g*NUM_BB+NUM_BB-1 into an internal signed partial sum of at least 18 bits, where g is the group counter, then increment g.
REQ-022 COMPUTE SHALL last N = ceil(Cx*Cy/NUM_BB) cycles. Examples with NUM_BB=4: 8x8 gives N = 4; 2x2 gives N = 1.
REQ-023 On the last COMPUTE edge: acc <= (acc_clr_reg ? 0 : acc) + sext(final partial sum), wrapping modulo 2^ACC_W; state goes to DONE. out_valid SHALL therefore rise exactly N edges after the accepting edge.
REQ-024 The partial sum SHALL equal the exact product x*y; no saturation or rounding.
REQ-025 DONE: out_valid = 1 and acc is held stable. When out_ready = 1, return to IDLE on that edge.
REQ-026 A new request SHALL not be accepted on the same edge as the DONE-to-IDLE transition (in_ready is 0 in DONE). Minimum issue interval is N+2 cycles.
REQ-027 in_ready SHALL be 0 in COMPUTE and DONE. in_valid, x and y are ignored there, and the registered operands SHALL not change mid-operation.
REQ-028 acc SHALL change only on the last COMPUTE edge or on reset.
REQ-029 When acc_clr = 1 the previous acc value SHALL not influence the result.
REQ-030 The accumulator SHALL wrap on overflow with no flag.
REQ-031 Precision code 3 SHALL behave identically to code 2.

Reset
REQ-032 While rst = 1 at a rising edge: state <= IDLE, acc <= 0, partial sum <= 0, group counter <= 0.
REQ-033 While rst is high: out_valid = 0, busy = 0, in_ready = 0. in_ready SHALL be 1 in the first cycle after rst deasserts.
REQ-034 Reset during COMPUTE or DONE SHALL abort the operation. No out_valid pulse is produced and acc reads 0 afterwards.

Verification
REQ-035 NUM_BB=4, 2-bit signed: x=2'b11, y=2'b10, s_x=s_y=1, acc_clr=1 -> out_valid 1 edge after accept, acc = 2.
REQ-036 NUM_BB=4, 8-bit unsigned: x=255, y=255, acc_clr=1 -> out_valid 4 edges after accept, acc = 65025. With NUM_BB=1 -> 16 edges, same acc.
REQ-037 8-bit signed: x=-128, y=-128, acc_clr=1 -> acc = 16384. Next request x=-128, y=127, acc_clr=0 -> acc = 128.
REQ-038 Mixed: x=8'hFF (8-bit, s_x=1), y=4'hF (4-bit, s_y=0), acc_clr=1 -> acc = -15, with N = 2 at NUM_BB=4.
REQ-039 Backpressure: out_ready held 0 for 5 cycles in DONE while in_valid=1 with new operands -> out_valid, acc and busy stay 1/stable and in_ready stays 0; the result is released on the first out_ready=1 edge.
REQ-040 rst asserted for 1 cycle during the 2nd COMPUTE cycle of an 8x8 operation -> no out_valid, acc = 0, in_ready = 1 on the next cycle, and the next request computes correctly.

Source files
------------

// File: rtl/fused_pe_if.sv
// fused_pe_if: operand request / result handshake bundle for fused_pe.
//   master side (producer/consumer of the PE) drives in_valid, x, y, s_x, s_y,
//   x_prec, y_prec, acc_clr and out_ready; it observes in_ready, out_valid,
//   acc and busy.
//   slave side (fused_pe) is the mirror image.
interface fused_pe_if #(
  parameter int ACC_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       x;
  logic [7:0]       y;
  logic             s_x;
  logic             s_y;
  logic [1:0]       x_prec;
  logic [1:0]       y_prec;
  logic             acc_clr;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc;
  logic             busy;

  modport master (
    output in_valid, x, y, s_x, s_y, x_prec, y_prec, acc_clr, out_ready,
    input  in_ready, out_valid, acc, busy
  );

  modport slave (
    input  in_valid, x, y, s_x, s_y, x_prec, y_prec, acc_clr, out_ready,
    output in_ready, out_valid, acc, busy
  );
endinterface

// File: rtl/fused_pe.sv
// fused_pe: bit-fusion style multiply-accumulate processing element.
//   An 8/4/2-bit x by 8/4/2-bit y product (each operand signed or unsigned)
//   is decomposed into 2-bit "brick" products; NUM_BB bricks are summed per
//   cycle into a partial sum, and the exact product is added into a wrapping
//   ACC_W-bit accumulator (optionally cleared first).
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - fused_pe_if.slave: in_valid/in_ready operand handshake, operands
//          x/y with sign flags and precision codes, acc_clr, out_valid/
//          out_ready result handshake, acc result, busy status.
module fused_pe #(
  parameter int NUM_BB = 4,
  parameter int ACC_W  = 32
) (
  input  logic     clk,
  input  logic     rst,
  fused_pe_if.slave bus
);

  // Largest exact product magnitude is 255*255 = 65025, so 18 signed bits
  // hold every final result; intermediate sums wrap harmlessly mod 2^18.
  localparam int PSUM_W = 18;

  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;

  state_t state, state_nxt;

  logic [7:0]               x_p0, y_p0;
  logic                     sx_p0, sy_p0, clr_p0;
  logic [1:0]               xl_p0, yl_p0;   // log2 of chunk count per operand

  logic signed [PSUM_W-1:0] psum, grp_sum, psum_nxt;
  logic [4:0]               grp;
  logic signed [ACC_W-1:0]  acc_r, acc_nxt;
  logic                     accept, last_grp;
  logic [5:0]               n_bricks, k_base;
  logic [9:0]               covered;

  // Precision code -> log2(number of 2-bit chunks); code 3 aliases code 2.
  function automatic logic [1:0] chunk_log(input logic [1:0] prec);
    case (prec)
      2'd0:    return 2'd0;
      2'd1:    return 2'd1;
      default: return 2'd2;
    endcase
  endfunction

  // One brick: x-chunk i times y-chunk j, aligned by 2*(i+j). Only the top
  // chunk of a signed operand carries the sign; indices past the last brick
  // contribute nothing.
  function automatic logic signed [PSUM_W-1:0] brick(
    input logic [7:0] xv,
    input logic [7:0] yv,
    input logic       sx,
    input logic       sy,
    input logic [1:0] cxl,
    input logic [1:0] cyl,
    input logic [5:0] k
  );
    logic [5:0]               i, j, cx, cy, total;
    logic [7:0]               xs, ys;
    logic signed [2:0]        xc, yc;
    logic signed [5:0]        prod;
    logic signed [PSUM_W-1:0] ext;
    logic [4:0]               shamt;
    cx    = 6'd1 << cxl;
    cy    = 6'd1 << cyl;
    total = 6'd1 << ({1'b0, cxl} + {1'b0, cyl});
    if (k >= total) return '0;
    i     = k >> cyl;
    j     = k & (cy - 6'd1);
    xs    = xv >> {i[3:0], 1'b0};
    ys    = yv >> {j[3:0], 1'b0};
    xc    = {sx && (i == cx - 6'd1) && xs[1], xs[1:0]};
    yc    = {sy && (j == cy - 6'd1) && ys[1], ys[1:0]};
    prod  = 6'(xc) * 6'(yc);
    ext   = PSUM_W'(prod);
    shamt = {i[3:0] + j[3:0], 1'b0};
    return ext <<< shamt;
  endfunction

  assign accept = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    bus.busy      = 1'b0;
    case (state)
      IDLE: begin
        bus.in_ready = !rst;
        if (bus.in_valid) state_nxt = COMPUTE;
      end
      COMPUTE: begin
        bus.busy = !rst;
        if (last_grp) state_nxt = DONE;
      end
      DONE: begin
        bus.busy      = !rst;
        bus.out_valid = !rst;
        if (bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: operands captured on acceptance, frozen for the whole operation.
  always_ff @(posedge clk) begin
    if (accept) begin
      x_p0   <= bus.x;
      y_p0   <= bus.y;
      sx_p0  <= bus.s_x;
      sy_p0  <= bus.s_y;
      xl_p0  <= chunk_log(bus.x_prec);
      yl_p0  <= chunk_log(bus.y_prec);
      clr_p0 <= bus.acc_clr;
    end
  end

  always_comb begin
    n_bricks = 6'd1 << ({1'b0, xl_p0} + {1'b0, yl_p0});
    k_base   = 6'(grp * NUM_BB);
    covered  = (10'(grp) + 10'd1) * 10'(NUM_BB);
    last_grp = covered >= {4'b0, n_bricks};
    grp_sum  = '0;
    for (int b = 0; b < NUM_BB; b++) begin
      grp_sum = grp_sum + brick(x_p0, y_p0, sx_p0, sy_p0, xl_p0, yl_p0,
                                k_base + 6'(b));
    end
    psum_nxt = psum + grp_sum;
    acc_nxt  = (clr_p0 ? '0 : acc_r) + ACC_W'(psum_nxt);
  end

  // Stage p1: brick-group accumulation; accumulator updates on the final group.
  always_ff @(posedge clk) begin
    if (rst) begin
      psum  <= '0;
      grp   <= '0;
      acc_r <= '0;
    end else if (accept) begin
      psum <= '0;
      grp  <= '0;
    end else if (state == COMPUTE) begin
      psum <= psum_nxt;
      grp  <= grp + 5'd1;
      if (last_grp) acc_r <= acc_nxt;
    end
  end

  assign bus.acc = acc_r;

endmodule
